// File: rtl/msrv32_pipe_skid_reg_if.sv
// Handshake bundle for msrv32_pipe_skid_reg.
// "slave" is the pipeline stage itself. "master" is whatever surrounds it:
// the upstream producer, the downstream consumer and the flush source.
interface msrv32_pipe_skid_reg_if #(
    parameter int DATA_W = 224,
    parameter int CTRL_W = 8
);
    logic              flush_in;
    logic              valid_in;
    logic              ready_out;
    logic [DATA_W-1:0] data_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic              valid_out;
    logic              ready_in;
    logic [DATA_W-1:0] data_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [15:0]       stall_cnt_out;

    modport slave (
        input  flush_in, valid_in, data_in, ctrl_in, ready_in,
        output ready_out, valid_out, data_out, ctrl_out, stall_cnt_out
    );

    modport master (
        output flush_in, valid_in, data_in, ctrl_in, ready_in,
        input  ready_out, valid_out, data_out, ctrl_out, stall_cnt_out
    );
endinterface

// File: rtl/msrv32_pipe_skid_reg.sv
// msrv32_pipe_skid_reg: generic inter-stage register with a two-entry skid buffer.
// It carries an opaque payload and side-effect enables, and it keeps ready_out
// fully registered. A synchronous flush kills every held entry.
// Optional macro MSRV32_PIPE_STATS_EN builds a saturating backpressure counter.
module msrv32_pipe_skid_reg #(
    parameter int DATA_W = 224,
    parameter int CTRL_W = 8
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    msrv32_pipe_skid_reg_if.slave   bus
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    logic              main_vld;
    logic              ready_q;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // The skid entry is valid exactly when the state is TWO, so it has no
    // separate valid flop. main_ctrl is cleared whenever the head goes invalid,
    // which keeps ctrl_out a plain register that still reads zero when empty.
    logic xfer_in;
    logic xfer_out;
    assign xfer_in  = bus.valid_in && ready_q;
    assign xfer_out = main_vld && bus.ready_in;

    // Handshake FSM and storage. Flush wins over every transfer.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state     <= EMPTY;
            main_vld  <= 1'b0;
            ready_q   <= 1'b0;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (bus.flush_in) begin
            state     <= EMPTY;
            main_vld  <= 1'b0;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            ready_q   <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    ready_q <= 1'b1;
                    if (xfer_in) begin
                        main_data <= bus.data_in;
                        main_ctrl <= bus.ctrl_in;
                        main_vld  <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_data <= bus.data_in;
                        main_ctrl <= bus.ctrl_in;
                        ready_q   <= 1'b1;
                    end else if (xfer_in) begin
                        skid_data <= bus.data_in;
                        skid_ctrl <= bus.ctrl_in;
                        state     <= TWO;
                        ready_q   <= 1'b0;
                    end else if (xfer_out) begin
                        main_vld  <= 1'b0;
                        main_ctrl <= '0;
                        state     <= EMPTY;
                        ready_q   <= 1'b1;
                    end else begin
                        ready_q   <= 1'b1;
                    end
                end
                TWO: begin
                    // ready_out is low here, so nothing can arrive.
                    if (xfer_out) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        skid_ctrl <= '0;
                        state     <= ONE;
                        ready_q   <= 1'b1;
                    end else begin
                        ready_q   <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    main_vld  <= 1'b0;
                    main_ctrl <= '0;
                    ready_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_out = ready_q;
    assign bus.valid_out = main_vld;
    assign bus.data_out  = main_data;
    assign bus.ctrl_out  = main_ctrl;

`ifdef MSRV32_PIPE_STATS_EN
    logic [15:0] stall_cnt;

    // Count cycles where the head is stuck behind downstream backpressure.
    // The count saturates, and flush does not clear it.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in)
            stall_cnt <= 16'h0000;
        else if (main_vld && !bus.ready_in && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign bus.stall_cnt_out = stall_cnt;
`else
    assign bus.stall_cnt_out = 16'h0000;
`endif

endmodule

// File: tb/tb_msrv32_pipe_skid_reg.sv
// Self-checking bench for msrv32_pipe_skid_reg.
// It runs a table of directed vectors, hand-written reset and flush sequences,
// and random traffic. Results are compared against a queue-based FIFO model.
module tb_msrv32_pipe_skid_reg;
    localparam int DW = 224;
    localparam int CW = 8;
`ifdef MSRV32_PIPE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    msrv32_pipe_skid_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

    msrv32_pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Reference model: a FIFO of up to two entries with a registered ready.
    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;
    ent_t        q[$];
    bit          m_rdy;
    int unsigned m_cnt;

    task automatic model_reset();
        q.delete();
        m_rdy = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        bit tin, tout;
        tin  = bus.valid_in && m_rdy;
        tout = (q.size() > 0) && bus.ready_in;
        if (q.size() > 0 && !bus.ready_in && m_cnt < 65535) m_cnt++;
        if (bus.flush_in) q.delete();
        else begin
            if (tout) void'(q.pop_front());
            if (tin)  q.push_back('{bus.data_in, bus.ctrl_in});
        end
        m_rdy = (q.size() < 2);
    endtask

    task automatic check_model(input string tag);
        logic [CW-1:0] ec;
        ec = (q.size() > 0) ? q[0].c : '0;
        chk({tag, ".valid"}, DW'(bus.valid_out), DW'(q.size() > 0));
        chk({tag, ".ready"}, DW'(bus.ready_out), DW'(m_rdy));
        chk({tag, ".ctrl"},  DW'(bus.ctrl_out),  DW'(ec));
        if (q.size() > 0) chk({tag, ".data"}, bus.data_out, q[0].d);
        chk({tag, ".stall"}, DW'(bus.stall_cnt_out), STATS ? DW'(m_cnt) : '0);
    endtask

    task automatic drive(input bit fl, input bit vi, input logic [DW-1:0] d,
                         input logic [CW-1:0] c, input bit ri);
        bus.flush_in = fl;
        bus.valid_in = vi;
        bus.data_in  = d;
        bus.ctrl_in  = c;
        bus.ready_in = ri;
    endtask

    task automatic step(input string tag, input bit fl, input bit vi, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input bit ri);
        drive(fl, vi, d, c, ri);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    // Directed vectors: inputs held for one edge, then the expected outputs.
    typedef struct {
        bit          fl;
        bit          vi;
        logic [31:0] d;
        logic [7:0]  c;
        bit          ri;
        bit          e_vo;
        logic [31:0] e_d;
        logic [7:0]  e_c;
        bit          e_ro;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit fl, bit vi, logic [31:0] d, logic [7:0] c, bit ri,
                                bit e_vo, logic [31:0] e_d, logic [7:0] e_c, bit e_ro);
        tbl.push_back('{fl, vi, d, c, ri, e_vo, e_d, e_c, e_ro});
    endfunction

    initial begin
        logic [DW-1:0] rd;
        // streaming 1..8, each on data_out right after its accepting edge
        for (int k = 1; k <= 8; k++) add(0, 1, 32'(k), 8'h01, 1, 1, 32'(k), 8'h01, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1);
        // backpressure while streaming 10, 11, 12
        add(0, 1, 10, 8'h0A, 1, 1, 10, 8'h0A, 1);
        add(0, 1, 11, 8'h0B, 0, 1, 10, 8'h0A, 0);   // 11 absorbed, ready_out falls
        add(0, 1, 12, 8'h0C, 0, 1, 10, 8'h0A, 0);   // 12 refused
        add(0, 1, 12, 8'h0C, 1, 1, 11, 8'h0B, 1);   // 10 out, 12 still refused
        add(0, 1, 12, 8'h0C, 1, 1, 12, 8'h0C, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1);
        // flush while TWO with a simultaneous arrival
        add(0, 1, 32'h20, 8'h05, 0, 1, 32'h20, 8'h05, 1);
        add(0, 1, 32'h21, 8'h06, 0, 1, 32'h20, 8'h05, 0);
        add(1, 1, 32'h22, 8'h07, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1);

        // power-on reset
        drive(0, 0, '0, '0, 0);
        #1 rst = 1'b1;
        #11;
        chk("rst.valid", DW'(bus.valid_out), '0);
        chk("rst.ready", DW'(bus.ready_out), '0);
        chk("rst.data",  bus.data_out, '0);
        chk("rst.ctrl",  DW'(bus.ctrl_out), '0);
        chk("rst.stall", DW'(bus.stall_cnt_out), '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst.ready_low", DW'(bus.ready_out), '0);
        step("rst_rel", 0, 0, '0, '0, 1);

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].fl, tbl[i].vi, DW'(tbl[i].d), tbl[i].c, tbl[i].ri);
            chk($sformatf("tbl%0d.valid", i), DW'(bus.valid_out), DW'(tbl[i].e_vo));
            chk($sformatf("tbl%0d.ready", i), DW'(bus.ready_out), DW'(tbl[i].e_ro));
            chk($sformatf("tbl%0d.ctrl", i),  DW'(bus.ctrl_out),  DW'(tbl[i].e_c));
            if (tbl[i].e_vo) chk($sformatf("tbl%0d.data", i), bus.data_out, DW'(tbl[i].e_d));
        end

        // mid-stream reset, with valid_in held high and data DEADBEEF
        step("pre_rst", 0, 1, DW'(32'hDEAD_BEEF), 8'h33, 1);
        drive(0, 1, DW'(32'hDEAD_BEEF), 8'h33, 0);
        @(posedge clk);
        model_edge();
        #2 rst = 1'b1;
        #1;
        chk("mrst.valid", DW'(bus.valid_out), '0);
        chk("mrst.ready", DW'(bus.ready_out), '0);
        chk("mrst.data",  bus.data_out, '0);
        chk("mrst.ctrl",  DW'(bus.ctrl_out), '0);
        chk("mrst.stall", DW'(bus.stall_cnt_out), '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mrst.ready_low", DW'(bus.ready_out), '0);
        step("mrst_rel", 0, 1, DW'(32'hDEAD_BEEF), 8'h33, 1);
        chk("mrst.no_accept", DW'(bus.valid_out), '0);
        chk("mrst.ready_high", DW'(bus.ready_out), DW'(1));

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rd = {7{$urandom()}};
            rd[31:0] = $urandom();
            step("rand", $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rd,
                 CW'($urandom()), $urandom_range(0, 2) != 0);
        end

        // long stall: head valid, downstream blocked
        step("stall_load", 0, 1, DW'(32'h55), 8'h01, 0);
`ifdef MSRV32_PIPE_STATS_EN
        drive(0, 0, '0, '0, 0);
        repeat (70000) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        chk("stats.sat", DW'(bus.stall_cnt_out), DW'(16'hFFFF));
        step("stats.flush", 1, 0, '0, '0, 0);
        chk("stats.keep", DW'(bus.stall_cnt_out), DW'(16'hFFFF));
`else
        for (int n = 0; n < 300; n++) step("nostats", 0, 0, '0, '0, 0);
        chk("nostats.zero", DW'(bus.stall_cnt_out), '0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
